// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: on a cache miss, issues one line-aligned memory read,
// assembles 64 read beats into a full line and returns it with a one-cycle fill pulse.
module cache_refill_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 16,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 8,
  parameter int BEAT_W   = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             miss_valid,
  input  logic [ADDR_W-1:0]                miss_addr,
  output logic                             miss_ready,
  output logic                             busy,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_ack,
  input  logic                             mem_rvalid,
  input  logic [BEAT_W-1:0]                mem_rdata,
  output logic                             fill_valid,
  output logic [TAG_W-1:0]                 fill_tag,
  output logic [INDEX_W-1:0]               fill_index,
  output logic [(2**OFFSET_W)*8-1:0]       fill_line,
  output logic [7:0]                       fill_byte
);

  localparam int LINE_W = (2**OFFSET_W) * 8;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [CNT_W-1:0]    beat_q,  beat_d;
  logic [LINE_W-1:0]   line_q,  line_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          addr_d  = miss_addr;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        // Beat k lands at bits [32k+31:32k]; gap cycles leave everything untouched.
        if (mem_rvalid) begin
          line_d[int'(beat_q)*BEAT_W +: BEAT_W] = mem_rdata;
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == CNT_W'(BEATS-1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign miss_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_req    = (state_q == REQ);
  assign fill_valid = (state_q == DONE);
  assign mem_addr   = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign fill_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign fill_index = addr_q[OFFSET_W +: INDEX_W];
  assign fill_line  = line_q;
  // Byte select from the held line; stable from DONE until the next accepted miss.
  assign fill_byte  = line_q[int'(addr_q[OFFSET_W-1:0])*8 +: 8];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: basic, delayed/gapped, busy-rejection,
// reset mid-fill and last-offset refills against hand-computed expectations.
module tb_cache_refill_ctrl;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_valid;
  logic [31:0]   miss_addr;
  logic          miss_ready;
  logic          busy;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          fill_valid;
  logic [15:0]   fill_tag;
  logic [7:0]    fill_index;
  logic [2047:0] fill_line;
  logic [7:0]    fill_byte;

  int n_tests = 0;
  int n_fail  = 0;

  cache_refill_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_tag   (fill_tag),
    .fill_index (fill_index),
    .fill_line  (fill_line),
    .fill_byte  (fill_byte)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge; outputs are then observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_pat(input int k);
    beat_pat = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  task automatic chk_line_bytes(input string tag);
    for (int b = 0; b < 256; b++) chk(tag, 64'(fill_line[8*b +: 8]), 64'(b));
  endtask

  // Accept a miss at edge 0, ack after ack_dly REQ cycles, stream 64 beats
  // (optionally with a gap after each), and check the fill outcome.
  task automatic run_refill(input logic [31:0] addr, input int ack_dly, input bit gaps,
                            input bit hold2, input int exp_edge, input logic [31:0] exp_maddr,
                            input logic [15:0] exp_tag, input logic [7:0] exp_idx,
                            input logic [7:0] exp_byte);
    int e;
    int fill_seen;
    fill_seen  = -1;
    miss_addr  = addr;
    miss_valid = 1'b1;
    chk("accept_ready", 64'(miss_ready), 64'd1);
    tick();
    e = 0;
    if (hold2) miss_addr = 32'h0001_FF00;
    else miss_valid = 1'b0;
    chk("req_busy", 64'(busy), 64'd1);
    chk("mem_addr", 64'(mem_addr), 64'(exp_maddr));
    for (int i = 1; i <= ack_dly; i++) begin
      chk("mem_req_held", 64'(mem_req), 64'd1);
      mem_ack    = (i == ack_dly);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      tick();
      e++;
    end
    mem_ack = 1'b0;
    chk("mem_req_drop", 64'(mem_req), 64'd0);
    for (int k = 0; k < 64; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = beat_pat(k);
      tick();
      e++;
      if (fill_valid && fill_seen < 0) fill_seen = e;
      if (hold2 && k < 63) chk("busy_reject", 64'({miss_ready, mem_req}), 64'd0);
      if (gaps && k < 63) begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        e++;
        if (fill_valid && fill_seen < 0) fill_seen = e;
      end
    end
    mem_rvalid = 1'b0;
    chk("fill_edge", 64'(fill_seen), 64'(exp_edge));
    chk("fill_valid", 64'(fill_valid), 64'd1);
    chk("done_ready", 64'(miss_ready), 64'd0);
    chk("fill_tag", 64'(fill_tag), 64'(exp_tag));
    chk("fill_index", 64'(fill_index), 64'(exp_idx));
    chk("fill_byte", 64'(fill_byte), 64'(exp_byte));
    chk_line_bytes("fill_line");
    tick();
    chk("fill_pulse_end", 64'(fill_valid), 64'd0);
    chk("idle_ready", 64'(miss_ready), 64'd1);
    chk("hold_byte", 64'(fill_byte), 64'(exp_byte));
    chk("hold_word63", 64'(fill_line[2047:2016]), 64'h0000_0000_FFFE_FDFC);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(miss_ready), 64'd1);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_req"},   64'(mem_req), 64'd0);
    chk({tag, "_fv"},    64'(fill_valid), 64'd0);
    chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_tag"},   64'(fill_tag), 64'd0);
    chk({tag, "_idx"},   64'(fill_index), 64'd0);
    chk({tag, "_byte"},  64'(fill_byte), 64'd0);
    chk({tag, "_line"},  64'(fill_line == '0), 64'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #3;
    chk_reset_vals("rst0");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic refill
    run_refill(32'h0001_FE01, 1, 1'b0, 1'b0, 65, 32'h0001_FE00, 16'h0001, 8'hFE, 8'h01);

    // Delayed ack, every-other-cycle beats
    run_refill(32'h0001_FE01, 5, 1'b1, 1'b0, 132, 32'h0001_FE00, 16'h0001, 8'hFE, 8'h01);

    // Second miss held during fill, accepted in the cycle after fill_valid
    run_refill(32'h0001_FE01, 1, 1'b0, 1'b1, 65, 32'h0001_FE00, 16'h0001, 8'hFE, 8'h01);
    run_refill(32'h0001_FF00, 1, 1'b0, 1'b0, 65, 32'h0001_FF00, 16'h0001, 8'hFF, 8'h00);

    // Reset in the middle of a fill
    miss_addr  = 32'h1234_5678;
    miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
    mem_ack    = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 30; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = beat_pat(k);
      tick();
    end
    chk("midfill_busy", 64'(busy), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    rst_n = 1'b1;
    for (int k = 30; k < 70; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = beat_pat(k % 64);
      tick();
      chk("post_rst_idle", 64'({fill_valid, miss_ready, mem_req}), 64'b010);
    end
    chk("post_rst_line", 64'(fill_line == '0), 64'd1);
    mem_rvalid = 1'b0;
    tick();
    run_refill(32'h0001_FE01, 1, 1'b0, 1'b0, 65, 32'h0001_FE00, 16'h0001, 8'hFE, 8'h01);

    // Last byte offset of the line
    run_refill(32'h0001_FEFF, 1, 1'b0, 1'b0, 65, 32'h0001_FE00, 16'h0001, 8'hFE, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-refill controller sitting directly downstream of the direct-mapped cache (32-bit byte address: 16-bit tag, 8-bit index, 8-bit offset; 256-byte lines, 2048 bits). On a reported miss it issues one line-aligned read to main memory, collects 64 word beats into a 2048-bit line buffer, then hands the complete line, tag, index and requested byte back to the cache in a single-cycle fill pulse.

## Interface
- ADDR_W, 32, byte address width
- TAG_W, 16, tag field width (addr[31:16])
- INDEX_W, 8, index field width (addr[15:8])
- OFFSET_W, 8, byte offset width (addr[7:0]); line = 2^OFFSET_W bytes
- BEAT_W, 32, memory read data width; beats per line = 2^OFFSET_W*8/BEAT_W = 64

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- miss_valid  in  1  cache reports a miss on miss_addr
- miss_addr  in  ADDR_W  missing byte address
- miss_ready  out  1  high only in IDLE; miss accepted when miss_valid & miss_ready
- busy  out  1  high in REQ, FILL, DONE
- mem_req  out  1  line read request, held until acknowledged
- mem_addr  out  ADDR_W  {latched addr[31:8], 8'h00}
- mem_ack  in  1  memory accepts request when mem_req & mem_ack
- mem_rvalid  in  1  one read beat valid this cycle
- mem_rdata  in  BEAT_W  beat data
- fill_valid  out  1  one-cycle pulse: line complete
- fill_tag  out  TAG_W  latched addr[31:16]
- fill_index  out  INDEX_W  latched addr[15:8]
- fill_line  out  2048  assembled line
- fill_byte  out  8  fill_line byte at latched offset

## Operation
- FSM states IDLE, REQ, FILL, DONE; all outputs registered or decoded from state.
- IDLE: miss_ready=1. On miss_valid: latch miss_addr, clear beat counter, go REQ.
- REQ: mem_req=1, mem_addr stable. On mem_ack go FILL. mem_rvalid in REQ ignored.
- FILL: 6-bit beat counter k. Each cycle with mem_rvalid: fill_line[32k+31:32k] <= mem_rdata, k <= k+1. Byte order: beat k byte 0 ([7:0]) is line byte 4k; line byte b occupies fill_line[8b+7:8b]. Gaps (mem_rvalid=0) stall with no state change. On beat with k==63: go DONE (counter wraps to 0).
- DONE: fill_valid=1 for exactly one cycle, then IDLE. fill_line/fill_tag/fill_index/fill_byte hold their values until next accepted miss.
- miss_valid while busy: ignored, not queued (miss_ready=0); cache must hold it.
- mem_ack outside REQ, mem_rvalid outside FILL: ignored.
- Reset (any state, asynchronous): state IDLE; miss_ready=1; busy, mem_req, fill_valid=0; mem_addr, fill_tag, fill_index, fill_byte, beat counter=0; fill_line=0. Partial line discarded; a beat arriving after reset deassertion is ignored (state IDLE).

## Timing
- Miss accepted at edge 0 -> mem_req high cycle 1.
- mem_ack sampled high at edge n -> FILL from cycle n+1; earliest first beat sampled edge n+1.
- 64 back-to-back beats with mem_ack at edge 1: last beat edge 65, fill_valid high cycle 66, miss_ready high cycle 67; minimum miss-to-fill 66 cycles.
- Each stall cycle adds exactly one cycle.
- fill_byte valid in same cycle as fill_valid.
- Next miss accepted earliest one cycle after fill_valid.

## Test plan
- Reset: rst_n low mid-clock -> all outputs at reset values immediately, miss_ready=1.
- Basic refill: miss_addr=32'h0001_FE01, mem_ack in first REQ cycle, beat k data=32'h{4k+3,4k+2,4k+1,4k} bytes -> mem_addr=32'h0001_FE00, fill_valid one cycle at 66 cycles after accept, fill_tag=16'h0001, fill_index=8'hFE, fill_byte=8'h01, fill_line byte b==b for all 256.
- Delayed ack and gapped beats: mem_ack after 5 cycles, rvalid low every other beat -> mem_req held 5 cycles, fill_valid exactly at accept+5+127+1, line identical to basic case.
- Busy rejection: second miss_valid (32'h0001_FF00) asserted during FILL -> miss_ready=0, no new mem_req until after fill_valid; held miss accepted cycle after fill_valid, fill_index=8'hFF, fill_byte=line byte 0.
- Reset mid-fill: assert rst_n low after 30 beats, release, keep rvalid driving -> no fill_valid, state IDLE, fill_line=0; fresh miss then completes normally.
- Last offset: miss_addr=32'h0001_FEFF -> fill_byte = byte 255 = mem_rdata[31:24] of beat 63.
